renkon_ctrl_pool: RTL and testbench

- Control stage directly downstream of the convolution control. It consumes the start/valid/stop stream that frames each output feature map (fea_size x fea_size pixels, raster order).
- It drives the max-pool datapath (line buffer plus comparator) for non-overlapping pool_size x pool_size windows with stride = pool_size.
- It emits an out_ctrl stream framing the pooled map to the next stage.

---
 rtl/renkon_ctrl_pool.sv | 165 ++++++++++++++++
 tb/tb_renkon_ctrl_pool.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_ctrl_pool.sv
// Max-pool control stage: tracks the feature-map raster, drives the line buffer
// and comparator, and reframes the pooled map for the next stage.
module renkon_ctrl_pool #(
  parameter int unsigned LWIDTH = 10,
  parameter int unsigned D_POOL = 2
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              in_ctrl_start,
  input  logic              in_ctrl_valid,
  input  logic              in_ctrl_stop,
  input  logic [LWIDTH-1:0] w_fea_size,
  input  logic [LWIDTH-1:0] w_pool_size,
  output logic              out_ctrl_start,
  output logic              out_ctrl_valid,
  output logic              out_ctrl_stop,
  output logic              buf_we,
  output logic              buf_init,
  output logic [LWIDTH-1:0] buf_addr,
  output logic              pool_oe,
  output logic [LWIDTH-1:0] w_out_size
);

  localparam logic [LWIDTH-1:0] One = LWIDTH'(1);

  typedef enum logic [0:0] {StWait, StActive} state_e;

  state_e state_q, state_d;

  logic [LWIDTH-1:0] fea_size_q, pool_size_q, out_size_q;
  logic [LWIDTH-1:0] fea_x_q, fea_y_q, pool_x_q, pool_y_q, out_x_q, out_y_q;
  logic [LWIDTH-1:0] fea_x_d, fea_y_d, pool_x_d, pool_y_d, out_x_d, out_y_d;
  logic [LWIDTH-1:0] out_size_calc;

  logic buf_we_q, buf_init_q, emit_q, last_q, start_q;
  logic [LWIDTH-1:0] buf_addr_q;
  logic [D_POOL-1:0] valid_pipe_q, start_pipe_q, stop_pipe_q;

  logic start_acc, valid_acc;
  logic last_x, last_y, last_px, last_py, in_region;

  assign start_acc = (state_q == StWait) && in_ctrl_start;
  assign valid_acc = (state_q == StActive) && in_ctrl_valid;
  assign last_x    = fea_x_q == fea_size_q - One;
  assign last_y    = fea_y_q == fea_size_q - One;
  assign last_px   = pool_x_q == pool_size_q - One;
  assign last_py   = pool_y_q == pool_size_q - One;
  assign in_region = (out_x_q < out_size_q) && (out_y_q < out_size_q);

  // A zero pool size is illegal; keep the divider output defined anyway.
  assign out_size_calc = (w_pool_size == '0) ? '0 : w_fea_size / w_pool_size;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (in_ctrl_start) state_d = StActive;
      StActive: if (out_ctrl_stop) state_d = StWait;
      default:  state_d = StWait;
    endcase
  end

  always_comb begin
    fea_x_d  = fea_x_q;
    fea_y_d  = fea_y_q;
    pool_x_d = pool_x_q;
    pool_y_d = pool_y_q;
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    if (start_acc) begin
      fea_x_d  = '0;
      fea_y_d  = '0;
      pool_x_d = '0;
      pool_y_d = '0;
      out_x_d  = '0;
      out_y_d  = '0;
    end else if (valid_acc) begin
      if (last_x) begin
        fea_x_d  = '0;
        pool_x_d = '0;
        out_x_d  = '0;
        if (last_y) begin
          fea_y_d  = '0;
          pool_y_d = '0;
          out_y_d  = '0;
        end else begin
          fea_y_d = fea_y_q + One;
          if (last_py) begin
            pool_y_d = '0;
            out_y_d  = out_y_q + One;
          end else begin
            pool_y_d = pool_y_q + One;
          end
        end
      end else begin
        fea_x_d = fea_x_q + One;
        if (last_px) begin
          pool_x_d = '0;
          out_x_d  = out_x_q + One;
        end else begin
          pool_x_d = pool_x_q + One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= StWait;
      fea_size_q   <= '0;
      pool_size_q  <= '0;
      out_size_q   <= '0;
      fea_x_q      <= '0;
      fea_y_q      <= '0;
      pool_x_q     <= '0;
      pool_y_q     <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      buf_we_q     <= 1'b0;
      buf_init_q   <= 1'b0;
      buf_addr_q   <= '0;
      emit_q       <= 1'b0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      valid_pipe_q <= '0;
      start_pipe_q <= '0;
      stop_pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        fea_size_q  <= w_fea_size;
        pool_size_q <= w_pool_size;
        out_size_q  <= out_size_calc;
      end
      fea_x_q    <= fea_x_d;
      fea_y_q    <= fea_y_d;
      pool_x_q   <= pool_x_d;
      pool_y_q   <= pool_y_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      buf_we_q   <= valid_acc && in_region;
      buf_init_q <= valid_acc && in_region && (pool_x_q == '0) && (pool_y_q == '0);
      buf_addr_q <= valid_acc ? out_x_q : '0;
      emit_q     <= valid_acc && in_region && last_px && last_py;
      last_q     <= valid_acc && last_x && last_y;
      start_q    <= start_acc;
      valid_pipe_q <= {valid_pipe_q[D_POOL-2:0], emit_q};
      start_pipe_q <= {start_pipe_q[D_POOL-2:0], start_q};
      stop_pipe_q  <= {stop_pipe_q[D_POOL-2:0], last_q};
    end
  end

  // Upstream stop must coincide with the final pixel of the frame.
  stop_check: assert property (@(posedge clk) disable iff (!xrst)
    ((state_q == StActive) && in_ctrl_stop) |-> (in_ctrl_valid && last_x && last_y));

  assign buf_we         = buf_we_q;
  assign buf_init       = buf_init_q;
  assign buf_addr       = buf_addr_q;
  assign out_ctrl_valid = valid_pipe_q[D_POOL-1];
  assign pool_oe        = valid_pipe_q[D_POOL-2];
  assign out_ctrl_start = start_pipe_q[D_POOL-1];
  assign out_ctrl_stop  = stop_pipe_q[D_POOL-1];
  assign w_out_size     = out_size_q;

endmodule

// File: tb/tb_renkon_ctrl_pool.sv
// Scoreboard bench for renkon_ctrl_pool: a raster model pushes expected buffer
// writes and output-event cycles; a negedge monitor pops and compares them.
module tb_renkon_ctrl_pool;

  localparam int LW = 10;
  localparam int DP = 2;

  logic clk, xrst;
  logic in_start, in_valid, in_stop;
  logic [LW-1:0] fea_size, pool_size;
  logic out_start, out_valid, out_stop;
  logic buf_we, buf_init, pool_oe;
  logic [LW-1:0] buf_addr, out_size;

  renkon_ctrl_pool #(.LWIDTH(LW), .D_POOL(DP)) dut (
    .clk           (clk),
    .xrst          (xrst),
    .in_ctrl_start (in_start),
    .in_ctrl_valid (in_valid),
    .in_ctrl_stop  (in_stop),
    .w_fea_size    (fea_size),
    .w_pool_size   (pool_size),
    .out_ctrl_start(out_start),
    .out_ctrl_valid(out_valid),
    .out_ctrl_stop (out_stop),
    .buf_we        (buf_we),
    .buf_init      (buf_init),
    .buf_addr      (buf_addr),
    .pool_oe       (pool_oe),
    .w_out_size    (out_size)
  );

  typedef struct {
    int init;
    int addr;
  } px_t;

  px_t px_q[$];
  int  out_q[$];
  int  st_q[$];
  int  sp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out, n_we;
  bit mon_en = 0;
  logic oe_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      px_t e;
      if (buf_we) begin
        n_we++;
        if (px_q.size() == 0) check("we_spurious", 1, 0);
        else begin
          e = px_q.pop_front();
          check("buf_init", int'(buf_init), e.init);
          check("buf_addr", int'(buf_addr), e.addr);
        end
      end else begin
        check("init_idle", int'(buf_init), 0);
      end
      if (out_valid) begin
        n_out++;
        if (out_q.size() == 0) check("valid_spurious", 1, 0);
        else check("valid_cyc", cyc, out_q.pop_front());
      end
      if (out_start) begin
        if (st_q.size() == 0) check("start_spurious", 1, 0);
        else check("start_cyc", cyc, st_q.pop_front());
      end
      if (out_stop) begin
        if (sp_q.size() == 0) check("stop_spurious", 1, 0);
        else check("stop_cyc", cyc, sp_q.pop_front());
      end
      check("oe_lead", int'(out_valid), int'(oe_prev));
      oe_prev = pool_oe;
    end
  end

  task automatic async_reset_check();
    mon_en = 1'b0;
    #2 xrst = 1'b0;
    #1;
    check("rst_we", int'(buf_we), 0);
    check("rst_init", int'(buf_init), 0);
    check("rst_addr", int'(buf_addr), 0);
    check("rst_oe", int'(pool_oe), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_start", int'(out_start), 0);
    check("rst_stop", int'(out_stop), 0);
    check("rst_osize", int'(out_size), 0);
    px_q.delete();
    out_q.delete();
    st_q.delete();
    sp_q.delete();
    in_valid = 1'b0;
    in_stop  = 1'b0;
    @(negedge clk);
    xrst    = 1'b1;
    oe_prev = 1'b0;
    mon_en  = 1'b1;
    @(negedge clk);
  endtask

  // dup_at: pixel index before which a stray start is injected; rst_at: pixel
  // index at which an async reset aborts the frame (-1 disables either).
  task automatic run_frame(input int fea, input int pool, input int gap_max,
                           input int dup_at, input int rst_at);
    int os, idx, k;
    px_t e;
    os    = fea / pool;
    n_out = 0;
    n_we  = 0;
    @(negedge clk);
    in_start  = 1'b1;
    fea_size  = LW'(fea);
    pool_size = LW'(pool);
    st_q.push_back(cyc + 1 + DP);
    @(negedge clk);
    in_start = 1'b0;
    check("out_size", int'(out_size), os);
    for (int y = 0; y < fea; y++) begin
      for (int x = 0; x < fea; x++) begin
        idx = y * fea + x;
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
        end
        if (idx == dup_at) begin
          in_valid  = 1'b0;
          in_start  = 1'b1;
          fea_size  = LW'(3);
          pool_size = LW'(1);
          @(negedge clk);
          in_start  = 1'b0;
          fea_size  = LW'(fea);
          pool_size = LW'(pool);
        end
        in_valid = 1'b1;
        if (idx == rst_at) begin
          async_reset_check();
          return;
        end
        in_stop = (idx == fea * fea - 1);
        if ((x / pool < os) && (y / pool < os)) begin
          e.init = ((x % pool == 0) && (y % pool == 0)) ? 1 : 0;
          e.addr = x / pool;
          px_q.push_back(e);
          if ((x % pool == pool - 1) && (y % pool == pool - 1)) out_q.push_back(cyc + 1 + DP);
        end
        if (idx == fea * fea - 1) sp_q.push_back(cyc + 1 + DP);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_stop  = 1'b0;
    k = 0;
    while (k < 40 && (px_q.size() + out_q.size() + st_q.size() + sp_q.size()) != 0) begin
      @(negedge clk);
      k++;
    end
    check("drain", px_q.size() + out_q.size() + st_q.size() + sp_q.size(), 0);
    check("n_out", n_out, os * os);
    check("n_we", n_we, os * os * pool * pool);
    check("out_size_end", int'(out_size), os);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    xrst      = 1'b0;
    in_start  = 1'b0;
    in_valid  = 1'b0;
    in_stop   = 1'b0;
    fea_size  = '0;
    pool_size = '0;
    repeat (2) @(negedge clk);
    check("init_we", int'(buf_we), 0);
    check("init_valid", int'(out_valid), 0);
    check("init_osize", int'(out_size), 0);
    xrst    = 1'b1;
    oe_prev = 1'b0;
    mon_en  = 1'b1;
    // valid/stop while idle must be ignored
    in_valid = 1'b1;
    in_stop  = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    in_stop  = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(4, 2, 0, -1, -1);
    run_frame(5, 2, 0, -1, -1);
    run_frame(6, 3, 3, -1, -1);
    run_frame(3, 1, 0, -1, -1);
    run_frame(4, 2, 0, 5, -1);
    run_frame(4, 2, 0, -1, 7);
    run_frame(4, 2, 1, -1, -1);
    run_frame(7, 7, 2, -1, -1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
